// File: rtl/load_store_unit.sv
// Load/store sequencer between execute and the data memory port: forms the effective
// address, screens funct3/alignment, waits out read latency and extends load data.
module load_store_unit #(
   parameter int READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_base,
   input  logic [31:0] req_offset,
   input  logic [31:0] req_store_data,
   input  logic [4:0]  req_rd,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_data,
   output logic [4:0]  resp_rd,
   output logic        resp_fault,
   output logic [31:0] dmem_address,
   output logic [2:0]  dmem_funct3,
   output logic        dmem_wren,
   output logic [31:0] dmem_data_in,
   input  logic [31:0] dmem_data_out
);

   localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   function automatic logic check_fault(input logic is_store, input logic [2:0] f3,
                                        input logic [1:0] lo);
      logic legal_v;
      logic aligned_v;
      case (f3)
         3'b000: begin legal_v = 1'b1;      aligned_v = 1'b1;           end
         3'b001: begin legal_v = 1'b1;      aligned_v = ~lo[0];         end
         3'b010: begin legal_v = 1'b1;      aligned_v = (lo == 2'b00);  end
         3'b100: begin legal_v = ~is_store; aligned_v = 1'b1;           end
         3'b101: begin legal_v = ~is_store; aligned_v = ~lo[0];         end
         default: begin legal_v = 1'b0;     aligned_v = 1'b1;           end
      endcase
      return ~(legal_v & aligned_v);
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] f3);
      logic [31:0] r_v;
      case (f3)
         3'b000:  r_v = {{24{d[7]}}, d[7:0]};
         3'b100:  r_v = {24'h000000, d[7:0]};
         3'b001:  r_v = {{16{d[15]}}, d[15:0]};
         3'b101:  r_v = {16'h0000, d[15:0]};
         3'b010:  r_v = d;
         default: r_v = 32'h0000_0000;
      endcase
      return r_v;
   endfunction

   state_t             state_r, state_s;
   logic               req_ready_r, req_ready_s;
   logic               resp_valid_r, resp_valid_s;
   logic [31:0]        resp_data_r, resp_data_s;
   logic [4:0]         resp_rd_r, resp_rd_s;
   logic               resp_fault_r, resp_fault_s;
   logic [31:0]        dmem_address_r, dmem_address_s;
   logic [2:0]         dmem_funct3_r, dmem_funct3_s;
   logic               dmem_wren_r, dmem_wren_s;
   logic [31:0]        dmem_data_in_r, dmem_data_in_s;
   logic [CNT_W-1:0]   wait_cnt_r, wait_cnt_s;
   logic [31:0]        ea_s;
   logic               req_fault_s;

   assign ea_s        = req_base + req_offset;
   assign req_fault_s = check_fault(req_is_store, req_funct3, ea_s[1:0]);

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_s        = state_r;
      req_ready_s    = req_ready_r;
      resp_valid_s   = resp_valid_r;
      resp_data_s    = resp_data_r;
      resp_rd_s      = resp_rd_r;
      resp_fault_s   = resp_fault_r;
      dmem_address_s = dmem_address_r;
      dmem_funct3_s  = dmem_funct3_r;
      dmem_wren_s    = 1'b0;
      dmem_data_in_s = dmem_data_in_r;
      wait_cnt_s     = wait_cnt_r;
      case (state_r)
         IDLE: begin
            if (req_valid && req_ready_r) begin
               req_ready_s  = 1'b0;
               resp_rd_s    = req_rd;
               resp_data_s  = 32'h0000_0000;
               resp_fault_s = req_fault_s;
               // Faulting requests never touch the memory port.
               if (req_fault_s) begin
                  state_s      = RESP;
                  resp_valid_s = 1'b1;
               end else begin
                  state_s        = ISSUE;
                  dmem_address_s = ea_s;
                  dmem_funct3_s  = req_funct3;
                  dmem_wren_s    = req_is_store;
                  if (req_is_store) begin
                     dmem_data_in_s = req_store_data;
                  end else begin
                     dmem_data_in_s = dmem_data_in_r;
                  end
               end
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            // The write strobe is only ever high during a store's issue cycle.
            if (dmem_wren_r) begin
               state_s      = RESP;
               resp_valid_s = 1'b1;
            end else begin
               state_s    = WAIT;
               wait_cnt_s = CNT_LOAD;
            end
         end
         WAIT: begin
            if (wait_cnt_r == {CNT_W{1'b0}}) begin
               state_s      = RESP;
               resp_valid_s = 1'b1;
               resp_data_s  = extend(dmem_data_out, dmem_funct3_r);
            end else begin
               wait_cnt_s = wait_cnt_r - CNT_W'(1);
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_s      = IDLE;
               resp_valid_s = 1'b0;
               req_ready_s  = 1'b1;
            end else begin
               state_s = RESP;
            end
         end
         default: begin
            state_s      = IDLE;
            req_ready_s  = 1'b1;
            resp_valid_s = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r        <= IDLE;
         req_ready_r    <= 1'b1;
         resp_valid_r   <= 1'b0;
         resp_data_r    <= 32'h0000_0000;
         resp_rd_r      <= 5'd0;
         resp_fault_r   <= 1'b0;
         dmem_address_r <= 32'h0000_0000;
         dmem_funct3_r  <= 3'b000;
         dmem_wren_r    <= 1'b0;
         dmem_data_in_r <= 32'h0000_0000;
         wait_cnt_r     <= {CNT_W{1'b0}};
      end else begin
         state_r        <= state_s;
         req_ready_r    <= req_ready_s;
         resp_valid_r   <= resp_valid_s;
         resp_data_r    <= resp_data_s;
         resp_rd_r      <= resp_rd_s;
         resp_fault_r   <= resp_fault_s;
         dmem_address_r <= dmem_address_s;
         dmem_funct3_r  <= dmem_funct3_s;
         dmem_wren_r    <= dmem_wren_s;
         dmem_data_in_r <= dmem_data_in_s;
         wait_cnt_r     <= wait_cnt_s;
      end
   end

   assign req_ready    = req_ready_r;
   assign resp_valid   = resp_valid_r;
   assign resp_data    = resp_data_r;
   assign resp_rd      = resp_rd_r;
   assign resp_fault   = resp_fault_r;
   assign dmem_address = dmem_address_r;
   assign dmem_funct3  = dmem_funct3_r;
   assign dmem_wren    = dmem_wren_r;
   assign dmem_data_in = dmem_data_in_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: one instance at READ_LATENCY=1, one at 3.
module tb_load_store_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        req_valid, req_valid3, resp_ready, resp_ready3;
   logic        req_is_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_base, req_offset, req_store_data;
   logic [4:0]  req_rd;

   logic        req_ready, resp_valid, resp_fault, dmem_wren;
   logic [31:0] resp_data, dmem_address, dmem_data_in, dmem_data_out;
   logic [4:0]  resp_rd;
   logic [2:0]  dmem_funct3;
   logic        req_ready3, resp_valid3, resp_fault3, dmem_wren3;
   logic [31:0] resp_data3, dmem_address3, dmem_data_in3, dmem_data_out3;
   logic [4:0]  resp_rd3;
   logic [2:0]  dmem_funct33;

   int          cyc = 0;
   int          wren_cnt = 0;
   int          issue_cyc = -100;
   int          issue_cyc3 = -100;
   logic [31:0] mem_word = 32'h0;
   int          passed = 0;
   int          total = 0;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        fault;
      int          lat;
   } exp_t;
   exp_t sb[$];

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (dmem_wren) wren_cnt <= wren_cnt + 1;

   // Memory model: read data is only valid in the last cycle of the read latency window.
   assign dmem_data_out  = (cyc == issue_cyc + 1)  ? mem_word : 32'hA5A5_A5A5;
   assign dmem_data_out3 = (cyc == issue_cyc3 + 3) ? mem_word : 32'h5A5A_5A5A;

   load_store_unit #(.READ_LATENCY(1)) dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_is_store(req_is_store), .req_funct3(req_funct3), .req_base(req_base),
      .req_offset(req_offset), .req_store_data(req_store_data), .req_rd(req_rd),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_rd(resp_rd), .resp_fault(resp_fault), .dmem_address(dmem_address),
      .dmem_funct3(dmem_funct3), .dmem_wren(dmem_wren), .dmem_data_in(dmem_data_in),
      .dmem_data_out(dmem_data_out)
   );

   load_store_unit #(.READ_LATENCY(3)) dut3 (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid3), .req_ready(req_ready3),
      .req_is_store(req_is_store), .req_funct3(req_funct3), .req_base(req_base),
      .req_offset(req_offset), .req_store_data(req_store_data), .req_rd(req_rd),
      .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_data(resp_data3),
      .resp_rd(resp_rd3), .resp_fault(resp_fault3), .dmem_address(dmem_address3),
      .dmem_funct3(dmem_funct33), .dmem_wren(dmem_wren3), .dmem_data_in(dmem_data_in3),
      .dmem_data_out(dmem_data_out3)
   );

   // Drives one request; returns at #1 after the accepting edge with t1 = that cycle number.
   task automatic send(input bit which3, input logic st, input logic [2:0] f3,
                       input logic [31:0] base, input logic [31:0] off,
                       input logic [31:0] sdata, input logic [4:0] rd, output int t1);
      int n = 0;
      @(negedge clk);
      while (((which3 ? req_ready3 : req_ready) !== 1'b1) && n < 20) begin
         @(negedge clk);
         n++;
      end
      req_is_store = st; req_funct3 = f3; req_base = base; req_offset = off;
      req_store_data = sdata; req_rd = rd;
      if (which3) req_valid3 = 1'b1;
      else req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; req_valid3 = 1'b0;
      t1 = cyc;
      if (which3) issue_cyc3 = t1;
      else issue_cyc = t1;
   endtask

   task automatic wait_resp(input bit which3, output logic [31:0] d, output logic [4:0] rd,
                            output logic f, output int at);
      int n = 0;
      while (((which3 ? resp_valid3 : resp_valid) !== 1'b1) && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      d  = which3 ? resp_data3 : resp_data;
      rd = which3 ? resp_rd3 : resp_rd;
      f  = which3 ? resp_fault3 : resp_fault;
      at = (n >= 40) ? -1000 : cyc;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; req_valid = 1'b0; req_valid3 = 1'b0; resp_ready = 1'b1; resp_ready3 = 1'b1;
      req_is_store = 1'b0; req_funct3 = 3'b000; req_base = 32'h0; req_offset = 32'h0;
      req_store_data = 32'h0; req_rd = 5'd0;
      repeat (2) @(posedge clk); #1;
      total++; if (req_ready !== 1'b1) $display("FAIL reset req_ready: got %b, expected 1", req_ready); else passed++;
      total++; if ({resp_valid, resp_fault, dmem_wren} !== 3'b000) $display("FAIL reset flags: got %b, expected 000", {resp_valid, resp_fault, dmem_wren}); else passed++;
      total++; if (dmem_address !== 32'h0) $display("FAIL reset dmem_address: got %h, expected 0", dmem_address); else passed++;
      total++; if (resp_data !== 32'h0) $display("FAIL reset resp_data: got %h, expected 0", resp_data); else passed++;
      total++; if (req_ready3 !== 1'b1) $display("FAIL reset req_ready3: got %b, expected 1", req_ready3); else passed++;
      @(negedge clk); reset_n = 1'b1;
   endtask

   task automatic test_store();
      logic [31:0] base_t [0:1] = '{32'hFFFF_FFF0, 32'h0000_1000};
      logic [31:0] off_t  [0:1] = '{32'h0000_000C, 32'h0000_0001};
      logic [31:0] dat_t  [0:1] = '{32'hFFFF_0000, 32'h1234_5678};
      logic [2:0]  f3_t   [0:1] = '{3'b010, 3'b000};
      logic [31:0] d; logic [4:0] rd; logic f; int at, t1, w0; exp_t e;
      for (int i = 0; i < 2; i++) begin
         w0 = wren_cnt;
         sb.push_back('{data: 32'h0, rd: 5'(7 + i), fault: 1'b0, lat: 2});
         send(1'b0, 1'b1, f3_t[i], base_t[i], off_t[i], dat_t[i], 5'(7 + i), t1);
         total++; if (dmem_address !== base_t[i] + off_t[i]) $display("FAIL store[%0d] addr: got %h, expected %h", i, dmem_address, base_t[i] + off_t[i]); else passed++;
         total++; if (dmem_funct3 !== f3_t[i]) $display("FAIL store[%0d] funct3: got %b, expected %b", i, dmem_funct3, f3_t[i]); else passed++;
         total++; if (dmem_wren !== 1'b1) $display("FAIL store[%0d] wren: got %b, expected 1", i, dmem_wren); else passed++;
         total++; if (dmem_data_in !== dat_t[i]) $display("FAIL store[%0d] data_in: got %h, expected %h", i, dmem_data_in, dat_t[i]); else passed++;
         wait_resp(1'b0, d, rd, f, at);
         e = sb.pop_front();
         total++; if (at - t1 + 1 !== e.lat) $display("FAIL store[%0d] latency: got %0d, expected %0d", i, at - t1 + 1, e.lat); else passed++;
         total++; if ({d, rd, f} !== {e.data, e.rd, e.fault}) $display("FAIL store[%0d] resp: got %h/%0d/%b, expected %h/%0d/%b", i, d, rd, f, e.data, e.rd, e.fault); else passed++;
         @(posedge clk); #1;
         total++; if (wren_cnt - w0 !== 1) $display("FAIL store[%0d] wren cycles: got %0d, expected 1", i, wren_cnt - w0); else passed++;
      end
   endtask

   task automatic test_loads();
      logic [2:0]  f3_t  [0:5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
      logic [31:0] ea_t  [0:5] = '{32'h1003, 32'h1003, 32'h2002, 32'h2002, 32'h3004, 32'h4000};
      logic [31:0] mem_t [0:5] = '{32'h0000_0080, 32'h0000_0080, 32'h0000_8001, 32'h0000_8001, 32'h89AB_CDEF, 32'h1234_567F};
      logic [31:0] exp_t_[0:5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001, 32'h89AB_CDEF, 32'h0000_007F};
      logic [31:0] d; logic [4:0] rd; logic f; int at, t1; exp_t e;
      for (int i = 0; i < 6; i++) begin
         mem_word = mem_t[i];
         sb.push_back('{data: exp_t_[i], rd: 5'(i + 1), fault: 1'b0, lat: 3});
         send(1'b0, 1'b0, f3_t[i], ea_t[i] - 32'h10, 32'h10, 32'hDEAD_0000, 5'(i + 1), t1);
         total++; if ({dmem_address, dmem_wren} !== {ea_t[i], 1'b0}) $display("FAIL load[%0d] issue: got %h/%b, expected %h/0", i, dmem_address, dmem_wren, ea_t[i]); else passed++;
         wait_resp(1'b0, d, rd, f, at);
         e = sb.pop_front();
         total++; if (at - t1 + 1 !== e.lat) $display("FAIL load[%0d] latency: got %0d, expected %0d", i, at - t1 + 1, e.lat); else passed++;
         total++; if (d !== e.data) $display("FAIL load[%0d] data: got %h, expected %h", i, d, e.data); else passed++;
         total++; if ({rd, f} !== {e.rd, e.fault}) $display("FAIL load[%0d] rd/fault: got %0d/%b, expected %0d/%b", i, rd, f, e.rd, e.fault); else passed++;
      end
   endtask

   task automatic test_faults();
      logic       st_t [0:4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [2:0] f3_t [0:4] = '{3'b001, 3'b011, 3'b010, 3'b100, 3'b010};
      logic [31:0] ea_t [0:4] = '{32'h1001, 32'h1000, 32'h1002, 32'h1000, 32'h1002};
      logic [31:0] d, a0; logic [4:0] rd; logic f; int at, t1, w0; exp_t e;
      w0 = wren_cnt;
      for (int i = 0; i < 5; i++) begin
         a0 = dmem_address;
         sb.push_back('{data: 32'h0, rd: 5'(20 + i), fault: 1'b1, lat: 1});
         send(1'b0, st_t[i], f3_t[i], ea_t[i], 32'h0, 32'hFFFF_FFFF, 5'(20 + i), t1);
         total++; if (dmem_address !== a0) $display("FAIL fault[%0d] addr moved: got %h, expected %h", i, dmem_address, a0); else passed++;
         wait_resp(1'b0, d, rd, f, at);
         e = sb.pop_front();
         total++; if (at - t1 + 1 !== e.lat) $display("FAIL fault[%0d] latency: got %0d, expected %0d", i, at - t1 + 1, e.lat); else passed++;
         total++; if ({d, rd, f} !== {e.data, e.rd, e.fault}) $display("FAIL fault[%0d] resp: got %h/%0d/%b, expected %h/%0d/%b", i, d, rd, f, e.data, e.rd, e.fault); else passed++;
      end
      @(posedge clk); #1;
      total++; if (wren_cnt !== w0) $display("FAIL fault wren: got %0d strobes, expected 0", wren_cnt - w0); else passed++;
   endtask

   task automatic test_backpressure();
      logic [31:0] d; logic [4:0] rd; logic f; int at, t1; exp_t e;
      resp_ready = 1'b0;
      mem_word = 32'h0BAD_F00D;
      sb.push_back('{data: 32'h0BAD_F00D, rd: 5'd9, fault: 1'b0, lat: 3});
      send(1'b0, 1'b0, 3'b010, 32'h5000, 32'h0, 32'h0, 5'd9, t1);
      wait_resp(1'b0, d, rd, f, at);
      e = sb.pop_front();
      total++; if (at - t1 + 1 !== e.lat) $display("FAIL hold latency: got %0d, expected %0d", at - t1 + 1, e.lat); else passed++;
      req_is_store = 1'b0; req_funct3 = 3'b000; req_base = 32'h6000; req_offset = 32'h0; req_rd = 5'd30;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++; if ({resp_valid, req_ready} !== 2'b10) $display("FAIL hold[%0d] valid/ready: got %b, expected 10", i, {resp_valid, req_ready}); else passed++;
         total++; if ({resp_data, resp_rd} !== {e.data, e.rd}) $display("FAIL hold[%0d] data/rd: got %h/%0d, expected %h/%0d", i, resp_data, resp_rd, e.data, e.rd); else passed++;
         req_valid = (i == 2);
      end
      @(negedge clk);
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      total++; if ({resp_valid, req_ready} !== 2'b01) $display("FAIL release valid/ready: got %b, expected 01", {resp_valid, req_ready}); else passed++;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         total++; if ({resp_valid, req_ready} !== 2'b01) $display("FAIL stray accept[%0d]: got %b, expected 01", i, {resp_valid, req_ready}); else passed++;
      end
   endtask

   task automatic test_wrap_latency();
      logic [31:0] d; logic [4:0] rd; logic f; int at, t1; exp_t e;
      mem_word = 32'hCAFE_F00D;
      sb.push_back('{data: 32'hCAFE_F00D, rd: 5'd12, fault: 1'b0, lat: 3});
      send(1'b0, 1'b0, 3'b010, 32'hFFFF_FFFC, 32'h8, 32'h0, 5'd12, t1);
      total++; if (dmem_address !== 32'h0000_0004) $display("FAIL wrap addr: got %h, expected 00000004", dmem_address); else passed++;
      wait_resp(1'b0, d, rd, f, at);
      e = sb.pop_front();
      total++; if (at - t1 + 1 !== e.lat) $display("FAIL wrap latency: got %0d, expected %0d", at - t1 + 1, e.lat); else passed++;
      total++; if ({d, rd, f} !== {e.data, e.rd, e.fault}) $display("FAIL wrap resp: got %h/%0d/%b, expected %h/%0d/%b", d, rd, f, e.data, e.rd, e.fault); else passed++;
      sb.push_back('{data: 32'hCAFE_F00D, rd: 5'd13, fault: 1'b0, lat: 5});
      send(1'b1, 1'b0, 3'b010, 32'hFFFF_FFFC, 32'h8, 32'h0, 5'd13, t1);
      total++; if (dmem_address3 !== 32'h0000_0004) $display("FAIL rl3 addr: got %h, expected 00000004", dmem_address3); else passed++;
      wait_resp(1'b1, d, rd, f, at);
      e = sb.pop_front();
      total++; if (at - t1 + 1 !== e.lat) $display("FAIL rl3 latency: got %0d, expected %0d", at - t1 + 1, e.lat); else passed++;
      total++; if ({d, rd, f} !== {e.data, e.rd, e.fault}) $display("FAIL rl3 resp: got %h/%0d/%b, expected %h/%0d/%b", d, rd, f, e.data, e.rd, e.fault); else passed++;
   endtask

   task automatic test_reset_in_wait();
      logic [31:0] d; logic [4:0] rd; logic f; int at, t1; exp_t e;
      mem_word = 32'h1111_1111;
      send(1'b0, 1'b0, 3'b010, 32'h6000, 32'h0, 32'h0, 5'd17, t1);
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      total++; if ({req_ready, resp_valid, resp_fault, dmem_wren} !== 4'b1000) $display("FAIL rst-wait flags: got %b, expected 1000", {req_ready, resp_valid, resp_fault, dmem_wren}); else passed++;
      total++; if ({dmem_address, dmem_data_in} !== 64'h0) $display("FAIL rst-wait dmem: got %h/%h, expected 0/0", dmem_address, dmem_data_in); else passed++;
      total++; if ({resp_data, resp_rd, dmem_funct3} !== 40'h0) $display("FAIL rst-wait resp: got %h/%0d/%b, expected 0/0/000", resp_data, resp_rd, dmem_funct3); else passed++;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         total++; if (resp_valid !== 1'b0) $display("FAIL rst-wait ghost resp[%0d]: got %b, expected 0", i, resp_valid); else passed++;
      end
      mem_word = 32'h0000_00FE;
      sb.push_back('{data: 32'h0000_00FE, rd: 5'd18, fault: 1'b0, lat: 3});
      send(1'b0, 1'b0, 3'b100, 32'h7000, 32'h2, 32'h0, 5'd18, t1);
      wait_resp(1'b0, d, rd, f, at);
      e = sb.pop_front();
      total++; if (at - t1 + 1 !== e.lat) $display("FAIL post-rst latency: got %0d, expected %0d", at - t1 + 1, e.lat); else passed++;
      total++; if ({d, rd, f} !== {e.data, e.rd, e.fault}) $display("FAIL post-rst resp: got %h/%0d/%b, expected %h/%0d/%b", d, rd, f, e.data, e.rd, e.fault); else passed++;
   endtask

   initial begin
      test_reset();
      test_store();
      test_loads();
      test_faults();
      test_backpressure();
      test_wrap_latency();
      test_reset_in_wait();
      repeat (2) @(posedge clk); #1;
      total++; if (sb.size() !== 0) $display("FAIL scoreboard leftover: got %0d, expected 0", sb.size()); else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", passed, total);
      $fatal(1);
   end

endmodule
